fft_iter_core: RTL and testbench

//   Iterative in-place radix-2 DIT FFT/IFFT over N complex points, one butterfly per clock.

---
 rtl/fft_pkg.sv | 29 ++
 rtl/fft_bfly.sv | 40 ++++
 rtl/fft_iter_core.sv | 93 +++++++++
 tb/tb_fft_iter_core.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: shared FSM states, complex sample type, bit reversal and twiddle generation.
package fft_pkg;
    typedef enum logic [1:0] {LOAD, CALC, DRAIN} state_t;

    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } cplx_t;

    function automatic logic [9:0] bitrev(input logic [9:0] k, input int bits);
        logic [9:0] r;
        r = '0;
        for (int i = 0; i < bits; i++) r[bits-1-i] = k[i];
        return r;
    endfunction

    function automatic int rnd(input real v);
        return v >= 0.0 ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    endfunction

    // W(t) = cos(2*pi*t/n) - j*sin(2*pi*t/n), rounded to nearest at frac bits
    function automatic int tw_re(input int t, input int n, input int frac);
        return rnd($cos(2.0 * 3.141592653589793 * t / n) * (2.0 ** frac));
    endfunction

    function automatic int tw_im(input int t, input int n, input int frac);
        return rnd(-$sin(2.0 * 3.141592653589793 * t / n) * (2.0 ** frac));
    endfunction
endpackage

// File: rtl/fft_bfly.sv
// fft_bfly: combinational radix-2 DIT butterfly; y0 = x0 + x1*W, y1 = x0 - x1*W.
// Define FFT_SCALE_EN to halve both outputs (floor) every stage.
module fft_bfly #(
    parameter int DW   = 16,
    parameter int FRAC = 11
) (
    input  logic [2*DW-1:0] x0,
    input  logic [2*DW-1:0] x1,
    input  logic [2*DW-1:0] w,
    input  logic            inv,
    output logic [2*DW-1:0] y0,
    output logic [2*DW-1:0] y1
);
    logic signed [DW-1:0] ar, ai, br, bi, wr, wi, pr, pi;
    logic signed [2*DW:0] sr, si;
    logic signed [DW:0] s0r, s0i, s1r, s1i;

    always_comb begin
        {ar, ai} = x0;
        {br, bi} = x1;
        wr = w[2*DW-1:DW];
        wi = inv ? -w[DW-1:0] : w[DW-1:0];
        sr = (2*DW+1)'(br) * (2*DW+1)'(wr) - (2*DW+1)'(bi) * (2*DW+1)'(wi);
        si = (2*DW+1)'(br) * (2*DW+1)'(wi) + (2*DW+1)'(bi) * (2*DW+1)'(wr);
        // bias negatives before the shift so the drop of FRAC bits truncates toward zero
        pr = DW'((sr + (sr < 0 ? (2*DW+1)'((1 << FRAC) - 1) : '0)) >>> FRAC);
        pi = DW'((si + (si < 0 ? (2*DW+1)'((1 << FRAC) - 1) : '0)) >>> FRAC);
        s0r = (DW+1)'(ar) + (DW+1)'(pr);
        s0i = (DW+1)'(ai) + (DW+1)'(pi);
        s1r = (DW+1)'(ar) - (DW+1)'(pr);
        s1i = (DW+1)'(ai) - (DW+1)'(pi);
`ifdef FFT_SCALE_EN
        y0 = {DW'(s0r >>> 1), DW'(s0i >>> 1)};
        y1 = {DW'(s1r >>> 1), DW'(s1i >>> 1)};
`else
        y0 = {DW'(s0r), DW'(s0i)};
        y1 = {DW'(s1r), DW'(s1i)};
`endif
    end
endmodule

// File: rtl/fft_iter_core.sv
// fft_iter_core: iterative in-place radix-2 DIT FFT/IFFT, one butterfly per clock.
// Define FFT_SCALE_EN for 1/N output scaling (handled in fft_bfly).
module fft_iter_core
    import fft_pkg::*;
#(
    parameter int N    = 16,
    parameter int DW   = 16,
    parameter int FRAC = 11
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   inv,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [2*DW-1:0]        s_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [2*DW-1:0]        m_data,
    output logic [$clog2(N)-1:0]   m_index,
    output logic                   m_last,
    output logic                   busy
);
    localparam int LOG2N = $clog2(N);
    localparam int HB = LOG2N - 1;

    state_t state, state_nx;
    logic [2*DW-1:0] mem [N];
    logic [2*DW-1:0] rom [N/2];
    logic [2*DW-1:0] y0, y1;
    logic [LOG2N-1:0] cnt, stg, i0, i1;
    logic [HB-1:0] b, t;
    logic inv_q, s_fire, m_fire, calc_end;

    for (genvar g = 0; g < N/2; g++) begin : g_rom
        assign rom[g] = {DW'(tw_re(g, N, FRAC)), DW'(tw_im(g, N, FRAC))};
    end

    always_comb begin
        s_ready  = state == LOAD;
        m_valid  = state == DRAIN;
        busy     = state != LOAD;
        m_index  = cnt;
        m_last   = m_valid && cnt == LOG2N'(N - 1);
        m_data   = m_valid ? mem[cnt] : '0;
        s_fire   = s_valid && s_ready;
        m_fire   = m_valid && m_ready;
        calc_end = state == CALC && b == HB'(N/2 - 1) && stg == LOG2N'(LOG2N - 1);
        i0 = LOG2N'(((32'(b) >> stg) << (stg + 1)) | (32'(b) & ((32'd1 << stg) - 1)));
        i1 = i0 + LOG2N'(32'd1 << stg);
        t  = HB'((32'(b) & ((32'd1 << stg) - 1)) << (HB - 32'(stg)));
        state_nx = (s_fire && cnt == LOG2N'(N - 1)) ? CALC :
                   calc_end                          ? DRAIN :
                   (m_fire && m_last)                ? LOAD : state;
    end

    fft_bfly #(.DW(DW), .FRAC(FRAC)) u_bfly (
        .x0 (mem[i0]),
        .x1 (mem[i1]),
        .w  (rom[t]),
        .inv(inv_q),
        .y0 (y0),
        .y1 (y1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD;
        else state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            stg   <= '0;
            b     <= '0;
            inv_q <= 1'b0;
            for (int k = 0; k < N; k++) mem[k] <= '0;
        end else begin
            if (s_fire) begin
                mem[LOG2N'(bitrev(10'(cnt), LOG2N))] <= s_data;
                cnt <= cnt + 1'b1;
                if (cnt == '0) inv_q <= inv;
            end
            // b wraps to 0 by width at the end of every stage
            if (state == CALC) begin
                mem[i0] <= y0;
                mem[i1] <= y1;
                b <= b + 1'b1;
                if (b == HB'(N/2 - 1)) stg <= calc_end ? '0 : stg + 1'b1;
            end
            if (m_fire) cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_fft_iter_core.sv
// tb_fft_iter_core: scoreboard bench for fft_iter_core at N=16, DW=16, FRAC=11.
`timescale 1ns/1ps
module tb_fft_iter_core;
    import fft_pkg::*;
    localparam int N = 16;
    localparam real PI = 3.141592653589793;
`ifdef FFT_SCALE_EN
    localparam real SC = 1.0 / 16;
    localparam int RT_TOL = 4;
`else
    localparam real SC = 1.0;
    localparam int RT_TOL = 16;
`endif

    typedef struct {int re; int im; int tol;} exp_t;

    logic clk = 0, rst_n = 1, inv = 0, s_valid = 0, m_ready = 1;
    logic s_ready, m_valid, m_last, busy;
    logic [31:0] s_data = '0, m_data, held_data = '0;
    logic [3:0] m_index, held_idx = '0;
    logic stall_rnd = 0, prev_stall = 0, prev_valid = 0;
    exp_t exp_q[$];
    int cmp = 0, errs = 0, cyc = 0, last_acc = 0, exp_idx = 0;
    int din_re[N], din_im[N], org_re[N], org_im[N], out_re[N], out_im[N];

    fft_iter_core #(.N(N), .DW(16), .FRAC(11)) dut (
        .clk(clk), .rst_n(rst_n), .inv(inv),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_index(m_index), .m_last(m_last), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input int obs, input int expv);
        cmp++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check_tol(input string tag, input int obs, input int expv, input int tol);
        cmp++;
        assert ((obs > expv ? obs - expv : expv - obs) <= tol) else begin
            errs++;
            $error("FAIL %s: got %0d expected %0d +/-%0d", tag, obs, expv, tol);
        end
    endtask

    // reference DFT of din_*, sign of the exponent chosen by iv
    task automatic push_dft(input logic iv, input int tol);
        for (int k = 0; k < N; k++) begin
            real sr, si, a, sg;
            sr = 0.0;
            si = 0.0;
            sg = iv ? 1.0 : -1.0;
            for (int n = 0; n < N; n++) begin
                a = 2.0 * PI * n * k / N;
                sr += din_re[n] * $cos(a) - din_im[n] * sg * $sin(a);
                si += din_re[n] * sg * $sin(a) + din_im[n] * $cos(a);
            end
            exp_q.push_back('{rnd(sr * SC), rnd(si * SC), tol});
        end
    endtask

    task automatic send_frame(input logic iv, input logic gap);
        for (int k = 0; k < N; k++) begin
            int n;
            if (gap && $urandom_range(1) == 0) begin
                s_valid = 0;
                @(posedge clk); #1;
            end
            s_valid = 1;
            inv = iv;
            s_data = {16'(din_re[k]), 16'(din_im[k])};
            n = 0;
            while (!s_ready && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
            check("s_ready", s_ready, 1);
            @(posedge clk); #1;
        end
        s_valid = 0;
        inv = 0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_left", exp_q.size(), 0);
    endtask

    initial forever begin
        @(posedge clk); #1;
        m_ready = stall_rnd ? ($urandom_range(99) >= 30) : 1'b1;
    end

    always @(negedge clk) begin
        cplx_t c;
        exp_t e;
        if (!rst_n) begin
            exp_idx = 0;
            prev_stall = 0;
            prev_valid = 0;
        end else begin
            if (prev_stall) begin
                check("stall_data", m_data, held_data);
                check("stall_idx", m_index, held_idx);
            end
            if (m_valid && !prev_valid) check("latency", cyc - last_acc, N / 2 * 4 + 1);
            if (s_valid && s_ready) last_acc = cyc;
            if (m_valid && m_ready) begin
                c = m_data;
                check("sb_nonempty", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_tol($sformatf("bin%0d_re", exp_idx), c.re, e.re, e.tol);
                    check_tol($sformatf("bin%0d_im", exp_idx), c.im, e.im, e.tol);
                end
                check("m_index", m_index, exp_idx);
                check("m_last", m_last, exp_idx == N - 1);
                out_re[exp_idx] = c.re;
                out_im[exp_idx] = c.im;
                exp_idx = (exp_idx + 1) % N;
            end
            prev_stall = m_valid && !m_ready;
            prev_valid = m_valid;
            held_data = m_data;
            held_idx = m_index;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 0;
        #1;
        check("rst_s_ready", s_ready, 1);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_index", m_index, 0);
        check("rst_m_last", m_last, 0);
        check("rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        // impulse
        for (int k = 0; k < N; k++) begin din_re[k] = 0; din_im[k] = 0; end
        din_re[0] = 2048;
        push_dft(0, 0);
        send_frame(0, 0);
        wait_drain();
        // DC
        for (int k = 0; k < N; k++) din_re[k] = 256;
        push_dft(0, 2);
        send_frame(0, 0);
        wait_drain();
        // single cosine cycle at full scale
        for (int k = 0; k < N; k++) din_re[k] = rnd(2048.0 * $cos(2.0 * PI * k / N));
        push_dft(0, 4);
        send_frame(0, 0);
        wait_drain();
        // round trip: random frame forward, then inverse on the captured spectrum
        for (int k = 0; k < N; k++) begin
            din_re[k] = $urandom_range(200) - 100;
            din_im[k] = $urandom_range(200) - 100;
            org_re[k] = din_re[k];
            org_im[k] = din_im[k];
        end
        push_dft(0, 8);
        send_frame(0, 0);
        wait_drain();
        for (int k = 0; k < N; k++) begin
            din_re[k] = out_re[k];
            din_im[k] = out_im[k];
            exp_q.push_back('{rnd(16.0 * org_re[k] * SC * SC), rnd(16.0 * org_im[k] * SC * SC), RT_TOL});
        end
        send_frame(1, 0);
        wait_drain();
        // gapped input and stalled output on the cosine frame
        for (int k = 0; k < N; k++) begin
            din_re[k] = rnd(2048.0 * $cos(2.0 * PI * k / N));
            din_im[k] = 0;
        end
        push_dft(0, 4);
        stall_rnd = 1;
        send_frame(0, 1);
        wait_drain();
        stall_rnd = 0;
        // reset during CALC cycle 10 aborts the frame
        for (int k = 0; k < N; k++) din_re[k] = 0;
        din_re[0] = 2048;
        send_frame(0, 0);
        repeat (9) @(posedge clk);
        #1;
        check("calc_busy", busy, 1);
        rst_n = 0;
        #1;
        check("abort_s_ready", s_ready, 1);
        check("abort_m_valid", m_valid, 0);
        check("abort_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1;
        push_dft(0, 0);
        send_frame(0, 0);
        wait_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule
